wb_arbiter: RTL
===============

# wb_arbiter

Writeback arbiter and scoreboard that drives the CPU register file's single write port (data, waddr, we). It merges single-cycle ALU results with long-latency load/store-unit (LSU) results. LSU results are buffered in a small FIFO and ALU starvation of that FIFO is bounded. A per-register busy mask lets decode stall on operands whose LSU writeback is still pending.

## Interface
Parameters:
- WORD, 32, data width; equals the register file word width.
- QDEPTH, 2, LSU result FIFO depth; power of two, 2..8.
- STARVE_MAX, 4, consecutive cycles the ALU may block a non-empty FIFO before the FIFO is forced; 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- alu_valid  in  1  ALU result offered.
- alu_ready  out  1  ALU result accepted when alu_valid & alu_ready.
- alu_rd  in  5  ALU destination register.
- alu_data  in  WORD  ALU result.
- lsu_valid  in  1  LSU result offered.
- lsu_ready  out  1  LSU result accepted when lsu_valid & lsu_ready.
- lsu_rd  in  5  LSU destination register.
- lsu_data  in  WORD  LSU result.
- issue_valid  in  1  long-latency op issued this cycle.
- issue_rd  in  5  destination register of the issued op.
- rf_data  out  WORD  register-file write data (registered).
- rf_waddr  out  5  register-file write address (registered).
- rf_we  out  1  register-file write enable (registered).
- busy  out  32  pending-write mask; bit n=1 means LSU write to xn is outstanding.

## Operation
- FIFO: QDEPTH entries of {rd, data}; read/write pointers with one extra wrap bit; full = pointers equal except the wrap bit.
- lsu_ready = !full, combinational from registered state only. It never depends on lsu_valid or alu_valid.
- An accepted LSU result with lsu_rd==0 is discarded and not enqueued.
- Commit selection each cycle, one write at most:
  - force = (starve_cnt == STARVE_MAX) & !empty.
  - If force: dequeue the head and commit it. alu_ready=0.
  - Else if alu_valid: commit the ALU result. alu_ready=1.
  - Else if !empty: dequeue the head and commit it. alu_ready=1.
  - alu_ready = !force, combinational.
- starve_cnt (4 bits):
  - Cleared when the FIFO is empty or the FIFO head commits.
  - Otherwise increments when an ALU result commits while the FIFO is non-empty.
  - Saturates at STARVE_MAX.
- A commit loads rf_data/rf_waddr. rf_we=1 iff the committed rd != 0, so an ALU write to x0 produces rf_we=0. With no commit, rf_we=0 and rf_data/rf_waddr hold their previous values.
- Enqueue and dequeue in the same cycle are legal when not full. The FIFO count is unchanged and the pointers wrap modulo QDEPTH.
- Scoreboard:
  - issue_valid & issue_rd!=0 sets busy[issue_rd].
  - A FIFO-head commit clears busy[head rd].
  - If the same register is set and cleared on one edge, set wins.
  - busy[0] is constant 0.
  - ALU commits never touch busy.

## Timing
- Reset (asynchronous): rf_we=0, rf_waddr=0, rf_data=0, busy=0, FIFO empty, starve_cnt=0. After reset, lsu_ready=1 and alu_ready=1.
- ALU latency: accepted at edge N gives rf_we visible after edge N.
- LSU latency: accepted at edge N is enqueued. The earliest commit is edge N+1, so rf_we is visible after edge N+1. There is no bypass.
- busy[rd] falls on the same edge that raises rf_we for that LSU write.
- An issue at edge N shows busy visible after edge N.
- Reset asserted mid-operation discards FIFO contents and pending writes. No partial write appears after release.

## Test plan
- Reset: assert rstn=0 mid-stream with 2 FIFO entries -> all outputs 0 immediately, busy=0, lsu_ready=1 after release, no rf_we pulse.
- ALU path: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF at edge 1 -> after edge 1 rf_we=1, rf_waddr=5, rf_data=0xDEADBEEF. Same with alu_rd=0 -> rf_we=0.
- LSU path and scoreboard: issue_rd=7 at edge 1, then lsu_rd=7, data=0x1234 accepted at edge 3 -> busy[7]=1 over edges 1..3, then rf_we=1 with waddr=7, data=0x1234 after edge 4, and busy[7]=0 after edge 4.
- FIFO full: QDEPTH=2, continuous alu_valid, three LSU offers -> the first two are accepted, then lsu_ready=0 until a dequeue. Order of LSU commits is preserved.
- Starvation: FIFO non-empty, alu_valid held high, STARVE_MAX=4 -> 4 ALU commits, then alu_ready=0 for one cycle and the FIFO head commits. The ALU resumes with the held result committing next.
- Set/clear collision: issue_rd=9 on the same edge the head with rd=9 commits -> rf_we=1 to x9 and busy[9] remains 1.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus bundle.
// Groups the ALU result channel, the LSU result channel, the long-latency
// issue notification and the register-file write port with the busy mask.
//   slave  : seen by wb_arbiter (consumes results, drives rf_* / busy / readies)
//   master : seen by the producer side (ALU, LSU, decode) or a testbench
interface wb_arbiter_if #(
  parameter int WORD = 32
);
  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [WORD-1:0] alu_data;
  logic            lsu_valid;
  logic            lsu_ready;
  logic [4:0]      lsu_rd;
  logic [WORD-1:0] lsu_data;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic [WORD-1:0] rf_data;
  logic [4:0]      rf_waddr;
  logic            rf_we;
  logic [31:0]     busy;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  issue_valid, issue_rd,
    output alu_ready, lsu_ready,
    output rf_data, rf_waddr, rf_we, busy
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output issue_valid, issue_rd,
    input  alu_ready, lsu_ready,
    input  rf_data, rf_waddr, rf_we, busy
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter and scoreboard for the single register-file write port.
// ALU results commit directly; LSU results go through a QDEPTH-entry FIFO.
// The ALU normally wins, but after STARVE_MAX consecutive ALU commits that
// block a non-empty FIFO the FIFO head is forced through for one cycle.
// Ports:
//   clk  : clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : wb_arbiter_if.slave (ALU/LSU/issue inputs, readies, rf_*, busy)
module wb_arbiter #(
  parameter int WORD       = 32,
  parameter int QDEPTH     = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rstn,
  wb_arbiter_if.slave   bus
);
  localparam int          PW         = $clog2(QDEPTH);
  localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);

  // FIFO storage and pointers (one extra wrap bit to tell full from empty)
  logic [4:0]      q_rd_r   [QDEPTH];
  logic [WORD-1:0] q_data_r [QDEPTH];
  logic [PW:0]     wr_ptr_r;
  logic [PW:0]     rd_ptr_r;
  logic [3:0]      starve_cnt_r;
  logic [31:0]     busy_r;
  logic [WORD-1:0] rf_data_r;
  logic [4:0]      rf_waddr_r;
  logic            rf_we_r;

  logic            empty_s;
  logic            full_s;
  logic            force_s;
  logic            head_commit_s;
  logic            alu_commit_s;
  logic            enq_s;
  logic [4:0]      head_rd_s;
  logic [WORD-1:0] head_data_s;
  logic [4:0]      commit_rd_s;
  logic [WORD-1:0] commit_data_s;
  logic [3:0]      starve_nxt_s;
  logic [31:0]     busy_nxt_s;

  assign head_rd_s   = q_rd_r[rd_ptr_r[PW-1:0]];
  assign head_data_s = q_data_r[rd_ptr_r[PW-1:0]];

  // Commit selection, starvation counter and scoreboard next-state
  always_comb begin
    empty_s = (wr_ptr_r == rd_ptr_r);
    full_s  = (wr_ptr_r[PW] != rd_ptr_r[PW]) &&
              (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
    force_s = (starve_cnt_r == STARVE_LIM) && !empty_s;

    // Forced head, or head when the ALU has nothing to offer
    head_commit_s = force_s || (!bus.alu_valid && !empty_s);
    alu_commit_s  = !force_s && bus.alu_valid;
    // Writes to x0 are dropped at the FIFO input
    enq_s         = bus.lsu_valid && !full_s && (bus.lsu_rd != 5'd0);

    if (head_commit_s) begin
      commit_rd_s   = head_rd_s;
      commit_data_s = head_data_s;
    end else begin
      commit_rd_s   = bus.alu_rd;
      commit_data_s = bus.alu_data;
    end

    if (empty_s || head_commit_s) begin
      starve_nxt_s = 4'd0;
    end else if (alu_commit_s && (starve_cnt_r != STARVE_LIM)) begin
      starve_nxt_s = starve_cnt_r + 4'd1;
    end else begin
      starve_nxt_s = starve_cnt_r;
    end

    // Clear first, then set, so a same-edge set on the same register wins
    busy_nxt_s = busy_r;
    if (head_commit_s) begin
      busy_nxt_s[head_rd_s] = 1'b0;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    if (bus.issue_valid && (bus.issue_rd != 5'd0)) begin
      busy_nxt_s[bus.issue_rd] = 1'b1;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    busy_nxt_s[0] = 1'b0;
  end

  // FIFO pointers and storage
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_rd_r[i]   <= 5'd0;
        q_data_r[i] <= '0;
      end
    end else begin
      if (enq_s) begin
        q_rd_r[wr_ptr_r[PW-1:0]]   <= bus.lsu_rd;
        q_data_r[wr_ptr_r[PW-1:0]] <= bus.lsu_data;
        wr_ptr_r                   <= wr_ptr_r + {{PW{1'b0}}, 1'b1};
      end
      if (head_commit_s) begin
        rd_ptr_r <= rd_ptr_r + {{PW{1'b0}}, 1'b1};
      end
    end
  end

  // Starvation counter, busy mask and registered write port
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_cnt_r <= 4'd0;
      busy_r       <= 32'd0;
      rf_data_r    <= '0;
      rf_waddr_r   <= 5'd0;
      rf_we_r      <= 1'b0;
    end else begin
      starve_cnt_r <= starve_nxt_s;
      busy_r       <= busy_nxt_s;
      if (head_commit_s || alu_commit_s) begin
        rf_data_r  <= commit_data_s;
        rf_waddr_r <= commit_rd_s;
        rf_we_r    <= (commit_rd_s != 5'd0);
      end else begin
        rf_we_r    <= 1'b0;
      end
    end
  end

  assign bus.alu_ready = !force_s;
  assign bus.lsu_ready = !full_s;
  assign bus.rf_data   = rf_data_r;
  assign bus.rf_waddr  = rf_waddr_r;
  assign bus.rf_we     = rf_we_r;
  assign bus.busy      = busy_r;
endmodule
